if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage.
//
// Issues word-aligned fetch requests to instruction memory, tracks how many
// responses are still in flight, and buffers returned words with their PC in
// a 2-entry FIFO that feeds the decoder. A redirect from execute retargets
// the fetch PC, empties the FIFO and marks every in-flight response as stale
// so it is dropped on return.
//
// Handshakes (all sampled on the rising clock edge):
//   imem_req/imem_gnt : a request is accepted in any cycle where both are 1.
//   imem_rvalid       : one response per accepted request, in request order,
//                       no earlier than the cycle after its grant.
//   if_valid/id_ready : the FIFO head is consumed in any cycle where both are 1.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/addr/gnt   fetch request channel
//   imem_rvalid/rdata   fetch response channel
//   redirect_valid/pc   taken branch/jump from execute (1-cycle pulse)
//   halt                blocks new requests; in-flight work still completes
//   id_ready            decoder accepts the head instruction
//   if_valid/instr/pc   instruction presented to the decoder
//   imem_err            sticky: response arrived with nothing outstanding
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        imem_err
);

  logic [31:0] pc_q;
  logic [31:0] resp_pc;
  logic [1:0]  outstanding;
  // Wider than a single stream needs: back-to-back redirects can stack
  // stale responses from several abandoned streams.
  logic [2:0]  discard;

  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  logic        grant;
  logic        pop;
  logic        resp_drop;
  logic        resp_keep;
  logic        resp_stray;
  logic        resp_taken;
  logic [2:0]  credit;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr    = pc_q & 32'hFFFF_FFFC;

  assign if_valid = (fifo_count != 2'd0);
  assign pop      = if_valid & id_ready;
  assign if_instr = if_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign if_pc    = if_valid ? fifo_pc[rd_ptr]    : 32'h0;

  // Every in-flight request owns a FIFO slot. A head leaving this cycle
  // frees its slot at the same edge, which is what lets a 1-cycle memory
  // sustain one instruction per cycle without ever overflowing the FIFO.
  assign credit   = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
  assign imem_req = ~rst & ~halt & ~redirect_valid & (credit < 3'd2);
  assign grant    = imem_req & imem_gnt;

  // Stale responses are drained first; only then does a response belong
  // to the current stream.
  assign resp_drop  = imem_rvalid & (discard != 3'd0);
  assign resp_keep  = imem_rvalid & (discard == 3'd0) & (outstanding != 2'd0);
  assign resp_stray = imem_rvalid & (discard == 3'd0) & (outstanding == 2'd0);
  assign resp_taken = resp_drop | resp_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc       <= RESET_PC;
      outstanding   <= 2'd0;
      discard       <= 3'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      imem_err      <= 1'b0;
    end else begin
      if (resp_stray) imem_err <= 1'b1;

      if (redirect_valid) begin
        // Everything still in flight belongs to the old stream, including
        // a response returning in this very cycle.
        pc_q        <= redirect_tgt;
        resp_pc     <= redirect_tgt;
        discard     <= discard + {1'b0, outstanding} - {2'b00, resp_taken};
        outstanding <= 2'd0;
        wr_ptr      <= 1'b0;
        rd_ptr      <= 1'b0;
        fifo_count  <= 2'd0;
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        if (resp_drop) discard <= discard - 3'd1;

        if (grant && !resp_keep)      outstanding <= outstanding + 2'd1;
        else if (!grant && resp_keep) outstanding <= outstanding - 2'd1;

        if (resp_keep) begin
          fifo_pc[wr_ptr]    <= resp_pc;
          fifo_instr[wr_ptr] <= imem_rdata;
          wr_ptr             <= ~wr_ptr;
          resp_pc            <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_count <= fifo_count + {1'b0, resp_keep} - {1'b0, pop};
      end
    end
  end

endmodule
